decoder_24: RTL and testbench
=============================

Name:
decoder_24

Overview:
- Registered 2-to-4 line decoder with enable.
- Select inputs a (MSB) and b (LSB) pick exactly one of four one-hot outputs y0..y3.
- Used as a small address/select decoder feeding chip-select or mux-select logic; the outputs are flop-driven so they are glitch-free downstream.

Parameters:
- ACTIVE_LOW_OUT, default 0: when 1, each y output is inverted at the port (the selected line is 0, the others 1); the reset level is inverted likewise.
- OUT_REG, default 1: when 1, outputs are registered with 1-cycle latency; when 0, outputs are combinational from a, b, en; reset still forces the inactive level.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  decode enable; when 0, no output is active
- a  input  1  select MSB
- b  input  1  select LSB
- y0  output  1  active when {a,b}=2'b00
- y1  output  1  active when {a,b}=2'b01
- y2  output  1  active when {a,b}=2'b10
- y3  output  1  active when {a,b}=2'b11

Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).

Behaviour:
- Decode function: sel={a,b}; yN active iff en=1 and sel==N. At most one output is active at any time.
- With OUT_REG=1:
  - Outputs update on each rising clk edge from a, b, en sampled at that edge.
  - Latency is 1 cycle, with no hold or pipeline bubbles.
  - A new select every cycle gives a new one-hot output every cycle.
- With OUT_REG=0: outputs follow the inputs combinationally while rst_n=1.
- Reset:
  - rst_n=0 forces all outputs to the inactive level immediately (asynchronously).
  - With ACTIVE_LOW_OUT=0, y0..y3=0; with ACTIVE_LOW_OUT=1, y0..y3=1.
  - Release is synchronous to clk in effect: the first decode appears on the first rising edge after rst_n returns to 1.
- Reset mid-operation: the active output drops at once; no stale value is restored after release.
- en=0: on the next edge, all outputs go inactive. a and b are ignored.
- Unknown inputs (X/Z on a, b or en): outputs are not required to be defined, but must not latch X across a subsequent valid cycle.
- ACTIVE_LOW_OUT inverts only at the port; internal state is always active-high one-hot.

Optional Feature:
- Macro DECODER_24_ONEHOT_CHK_EN.
- When defined:
  - Adds output onehot_err (1 bit, registered, reset 0).
  - onehot_err is set to 1 for one cycle whenever the internal active-high output vector is neither all-zero nor exactly one-hot. This catches SEU or coding faults.
  - Adds a simulation-only immediate assertion with the same check.
- When not defined: the port and logic are absent, and the interface is exactly as listed above.

Decomposition:
- Package decoder_24_pkg holds:
  - localparam SEL_W=2 and OUT_N=4
  - typedef sel_t (logic [1:0]) and onehot_t (logic [3:0])
  - function onehot_of(sel_t) returning the one-hot vector
- One sub-module is natural: decoder_24_comb, a pure combinational sel+en -> onehot_t decoder.
- The top module adds the register stage, reset handling, port polarity, and the optional checker.

Test Plan:
1. Reset: hold rst_n=0 with a=1, b=1, en=1 → y0..y3=0000 throughout, independent of clk; ACTIVE_LOW_OUT=1 build → 1111.
2. Full sweep, en=1, OUT_REG=1: drive {a,b}=00, 01, 10, 11, each held 100 ns → one edge later {y3,y2,y1,y0}=0001, 0010, 0100, 1000 respectively.
3. Enable gating: {a,b}=10, en toggles 1→0→1 → y2=1, then all 0 one cycle after en=0, then y2=1 again one cycle after en=1.
4. Back-to-back select changes every clock (00→11→01→10) → outputs track with exactly 1-cycle latency, one-hot at every sampled edge.
5. Mid-operation reset: y3 active, assert rst_n=0 between edges → y3 drops immediately; after release with {a,b}=01, y1=1 on the first edge.
6. With DECODER_24_ONEHOT_CHK_EN: normal sweep → onehot_err stays 0; force the internal register to 0110 → onehot_err=1 on the next cycle.

Source files
------------

// File: rtl/decoder_24_pkg.sv
// Shared types and helpers for the registered 2-to-4 decoder.
package decoder_24_pkg;

   localparam int SEL_W = 2;
   localparam int OUT_N = 4;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [OUT_N-1:0] onehot_t;

   // One-hot vector with bit 'sel' set.
   function automatic onehot_t onehot_of(input sel_t sel);
      onehot_t r;
      r      = '0;
      r[sel] = 1'b1;
      return r;
   endfunction

   // True when more than one bit is set (neither zero nor one-hot).
   function automatic logic is_multi_hot(input onehot_t v);
      return (v & (v - onehot_t'(1))) != '0;
   endfunction

endpackage

// File: rtl/decoder_24_comb.sv
// Pure combinational select+enable to active-high one-hot decoder.
module decoder_24_comb
   import decoder_24_pkg::*;
(
   input  sel_t    sel,
   input  logic    en,
   output onehot_t onehot
);

   // Decode the select; no line is active while disabled.
   always_comb begin
      // NOTE: the output gets a value on every path, so no latch is inferred.
      onehot = '0;
      if (en) begin
         onehot = onehot_of(sel);
      end
   end

endmodule

// File: rtl/decoder_24.sv
// Registered 2-to-4 line decoder with enable.
// ACTIVE_LOW_OUT inverts the y ports only; the internal vector is active-high.
// OUT_REG selects a 1-cycle registered or a combinational output path.
// Optional macro DECODER_24_ONEHOT_CHK_EN adds the onehot_err output and a
// one-hot integrity check on the internal vector.
module decoder_24
   import decoder_24_pkg::*;
#(
   parameter bit ACTIVE_LOW_OUT = 1'b0,
   parameter bit OUT_REG        = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic y0,
   output logic y1,
   output logic y2,
   output logic y3
`ifdef DECODER_24_ONEHOT_CHK_EN
   ,
   output logic onehot_err
`endif
);

   localparam onehot_t POL_MASK = ACTIVE_LOW_OUT ? '1 : '0;

   sel_t    sel;
   onehot_t y_d;
   onehot_t y_int;
   onehot_t y_port;

   assign sel = {a, b};

   decoder_24_comb u_comb (
      .sel    (sel),
      .en     (en),
      .onehot (y_d)
   );

   generate
      if (OUT_REG) begin : g_reg
         onehot_t y_q;

         // Output register; reset clears it to the inactive (all-zero) state.
         always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (!rst_n) begin
               y_q <= '0;
            end else begin
               y_q <= y_d;
            end
         end

         assign y_int = y_q;
      end else begin : g_comb
         // Combinational path, still forced inactive while in reset.
         assign y_int = rst_n ? y_d : '0;
      end
   endgenerate

   assign y_port = y_int ^ POL_MASK;
   assign y0     = y_port[0];
   assign y1     = y_port[1];
   assign y2     = y_port[2];
   assign y3     = y_port[3];

`ifdef DECODER_24_ONEHOT_CHK_EN
   logic onehot_err_d;
   logic onehot_err_q;

   // Flag an internal vector that is neither idle nor one-hot.
   always_comb begin
      onehot_err_d = is_multi_hot(y_int);
   end

   // Register the flag so it is glitch-free like the y outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         onehot_err_q <= 1'b0;
      end else begin
         onehot_err_q <= onehot_err_d;
      end
   end

   assign onehot_err = onehot_err_q;

`ifndef SYNTHESIS
   // Simulation-time report of the same integrity condition.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!is_multi_hot(y_int))
            else $warning("decoder_24: internal vector %b is not one-hot", y_int);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_decoder_24.sv
// Directed self-checking bench for decoder_24: registered active-high DUT,
// an active-low-output copy and a combinational (OUT_REG=0) copy.
`timescale 1ns/1ps
module tb_decoder_24;

   logic clk;
   logic rst_n;
   logic en;
   logic a;
   logic b;
   logic y0, y1, y2, y3;
   logic l0, l1, l2, l3;
   logic c0, c1, c2, c3;
`ifdef DECODER_24_ONEHOT_CHK_EN
   logic onehot_err;
   logic l_err;
   logic c_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   decoder_24 #(.ACTIVE_LOW_OUT(1'b0), .OUT_REG(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3)
`ifdef DECODER_24_ONEHOT_CHK_EN
      , .onehot_err(onehot_err)
`endif
   );

   decoder_24 #(.ACTIVE_LOW_OUT(1'b1), .OUT_REG(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
      .y0(l0), .y1(l1), .y2(l2), .y3(l3)
`ifdef DECODER_24_ONEHOT_CHK_EN
      , .onehot_err(l_err)
`endif
   );

   decoder_24 #(.ACTIVE_LOW_OUT(1'b0), .OUT_REG(1'b0)) dut_cb (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
      .y0(c0), .y1(c1), .y2(c2), .y3(c3)
`ifdef DECODER_24_ONEHOT_CHK_EN
      , .onehot_err(c_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #1ms;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Apply inputs away from the active edge.
   task automatic drive(input logic ia, input logic ib, input logic ien);
      @(negedge clk);
      a  = ia;
      b  = ib;
      en = ien;
   endtask

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] main_y();
      return {y3, y2, y1, y0};
   endfunction

   function automatic logic [3:0] al_y();
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [3:0] cb_y();
      return {c3, c2, c1, c0};
   endfunction

   // Hand-computed one-hot codes for {a,b} = 00, 01, 10, 11.
   logic [3:0] sweep_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   // Back-to-back sequence 00 -> 11 -> 01 -> 10 and its expected outputs.
   logic [1:0] b2b_sel [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
   logic [3:0] b2b_exp [4] = '{4'b0001, 4'b1000, 4'b0010, 4'b0100};

   initial begin
      logic [1:0] s;

      // Reset held with active-looking inputs.
      rst_n = 1'b0;
      a = 1'b1; b = 1'b1; en = 1'b1;
      #3;
      check("reset_pre_clk",     main_y(), 4'b0000);
      check("reset_pre_clk_al",  al_y(),   4'b1111);
      check("reset_pre_clk_cb",  cb_y(),   4'b0000);
      step();
      step();
      check("reset_clocked",     main_y(), 4'b0000);
      check("reset_clocked_al",  al_y(),   4'b1111);
      check("reset_clocked_cb",  cb_y(),   4'b0000);

      // Release; first decode lands on the first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      a = 1'b0; b = 1'b0; en = 1'b1;
      #1;
      check("release_no_edge",   main_y(), 4'b0000);
      step();
      check("release_first_edge", main_y(), 4'b0001);

      // Full sweep with en=1, each select held about 100 ns.
      for (int i = 0; i < 4; i++) begin
         s = 2'(i);
         drive(s[1], s[0], 1'b1);
         #1;
         check("sweep_comb",     cb_y(),   sweep_exp[i]);
         step();
         check("sweep_edge",     main_y(), sweep_exp[i]);
         check("sweep_edge_al",  al_y(),   ~sweep_exp[i]);
         repeat (9) step();
         check("sweep_hold",     main_y(), sweep_exp[i]);
      end

      // Enable gating with {a,b}=10.
      drive(1'b1, 1'b0, 1'b1);
      step();
      check("en_on",        main_y(), 4'b0100);
      drive(1'b1, 1'b0, 1'b0);
      #1;
      check("en_off_comb",  cb_y(),   4'b0000);
      check("en_off_wait",  main_y(), 4'b0100);
      step();
      check("en_off",       main_y(), 4'b0000);
      check("en_off_al",    al_y(),   4'b1111);
      drive(1'b1, 1'b0, 1'b1);
      step();
      check("en_on_again",  main_y(), 4'b0100);

      // Back-to-back select changes: exactly one cycle of latency.
      for (int i = 0; i < 4; i++) begin
         drive(b2b_sel[i][1], b2b_sel[i][0], 1'b1);
         #1;
         check("b2b_before_edge", main_y(), (i == 0) ? 4'b0100 : b2b_exp[i-1]);
         step();
         check("b2b_after_edge",  main_y(), b2b_exp[i]);
      end

      // Reset in the middle of operation.
      drive(1'b1, 1'b1, 1'b1);
      step();
      check("mid_y3_active", main_y(), 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_drop",    main_y(), 4'b0000);
      check("mid_rst_drop_al", al_y(),   4'b1111);
      check("mid_rst_drop_cb", cb_y(),   4'b0000);
      drive(1'b0, 1'b1, 1'b1);
      rst_n = 1'b1;
      #1;
      check("mid_release_no_edge", main_y(), 4'b0000);
      step();
      check("mid_release_edge", main_y(), 4'b0010);

      // Unknown select must not persist past a valid cycle.
      drive(1'bx, 1'b0, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b1);
      step();
      check("x_recovered", main_y(), 4'b0001);

`ifdef DECODER_24_ONEHOT_CHK_EN
      check("chk_clean", {3'b000, onehot_err}, 4'b0000);
      @(negedge clk);
      force dut.g_reg.y_q = 4'b0110;
      step();
      check("chk_flagged", {3'b000, onehot_err}, 4'b0001);
      release dut.g_reg.y_q;
      step();
      step();
      check("chk_cleared", {3'b000, onehot_err}, 4'b0000);
      check("chk_output_back", main_y(), 4'b0001);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
